// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: control and status bundle for the counter_ctrl run controller.
// Ports: start/stop/hold/limit are driven by the master (control logic or bench).
//        out/busy/done/state are driven by the slave (counter_ctrl).
interface counter_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic             stop;
    logic             hold;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic [1:0]       state;
    modport master (output start, stop, hold, limit, input out, busy, done, state);
    modport slave  (input start, stop, hold, limit, output out, busy, done, state);
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: run controller for an up-counter with start/hold/stop and terminal-count done pulse.
// Ports: clk, rst (synchronous, active-high); bus (counter_ctrl_if.slave):
//        start/stop/hold/limit in, out/busy/done/state out.
// Optional feature: define COUNTER_CTRL_AUTORELOAD_EN to restart from 0 at terminal count
// instead of parking in DONE.
module counter_ctrl #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            lim_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            lim_q   <= lim_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        lim_d   = lim_q;
        done_d  = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
            out_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        out_d   = '0;
                        lim_d   = bus.limit;
                    end
                end
                RUN, HOLD: begin
                    if (bus.hold) begin
                        state_d = HOLD;
                    end else if (out_q != lim_q) begin
                        state_d = RUN;
                        out_d   = out_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                        state_d = RUN;
                        out_d   = '0;
`else
                        state_d = DONE;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.out   = out_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;
    assign bus.busy  = (state_q == RUN) || (state_q == HOLD);
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed self-checking bench for counter_ctrl with a progress-based reference model.
module tb_counter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    counter_ctrl_if #(.WIDTH(8)) bus ();
    counter_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a run is tracked as the number of non-held cycles since the
    // accepted start; the terminal count completes once that exceeds the latched limit.
    int m_mode = 0;   // 0 idle, 1 run, 2 hold, 3 done
    int m_steps = 0;
    int m_lim = 0;
    bit m_done = 1'b0;
    bit m_valid = 1'b0;

    always begin
        @(posedge clk);
        m_done = 1'b0;
        if (rst) begin
            m_mode = 0; m_steps = 0; m_lim = 0; m_valid = 1'b1;
        end else if (bus.stop) begin
            m_mode = 0; m_steps = 0;
        end else if ((m_mode == 0 || m_mode == 3) && bus.start) begin
            m_mode = 1; m_steps = 0; m_lim = int'(bus.limit);
        end else if (m_mode == 1 || m_mode == 2) begin
            if (bus.hold) m_mode = 2;
            else begin
                m_mode = 1;
                m_steps++;
                if (m_steps > m_lim) begin
                    m_done = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                    m_steps = 0;
`else
                    m_mode = 3;
                    m_steps = m_lim;
`endif
                end
            end
        end
        #1;
        if (m_valid) begin
            check("model_out", int'(bus.out), m_steps);
            check("model_state", int'(bus.state), m_mode);
            check("model_busy", int'(bus.busy), int'(m_mode == 1 || m_mode == 2));
            check("model_done", int'(bus.done), int'(m_done));
        end
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.limit = '0;
        tick(2);
        rst = 1'b0;
        check("rst_out", int'(bus.out), 0);
        check("rst_state", int'(bus.state), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
`ifndef COUNTER_CTRL_AUTORELOAD_EN
        // limit 5: out 0..5, done one cycle later, park in DONE
        bus.limit = 8'd5; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("t1_out0", int'(bus.out), 0);
        check("t1_busy", int'(bus.busy), 1);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check("t1_out_k", int'(bus.out), k);
            check("t1_nodone", int'(bus.done), 0);
        end
        tick(1);
        check("t1_done", int'(bus.done), 1);
        check("t1_state", int'(bus.state), 3);
        check("t1_busy_done", int'(bus.busy), 0);
        check("t1_out_hold", int'(bus.out), 5);
        tick(1);
        check("t1_done_pulse", int'(bus.done), 0);
        check("t1_out_park", int'(bus.out), 5);
        // limit 10 with 3 held cycles at out=4: done 14 cycles after start
        bus.limit = 8'd10; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(4);
        check("t2_out4", int'(bus.out), 4);
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("t2_held_out", int'(bus.out), 4);
            check("t2_held_state", int'(bus.state), 2);
        end
        bus.hold = 1'b0;
        tick(1);
        check("t2_resume", int'(bus.out), 5);
        tick(5);
        check("t2_out10", int'(bus.out), 10);
        check("t2_not_yet", int'(bus.done), 0);
        tick(1);
        check("t2_done", int'(bus.done), 1);
        // limit 200 stopped at out=50
        bus.limit = 8'd200; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(50);
        check("t3_out50", int'(bus.out), 50);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("t3_stop_out", int'(bus.out), 0);
        check("t3_stop_state", int'(bus.state), 0);
        check("t3_stop_done", int'(bus.done), 0);
        bus.start = 1'b1; bus.stop = 1'b1;
        tick(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("t3_stop_wins", int'(bus.state), 0);
        // limit 0 then limit 255
        bus.limit = 8'd0; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("t4_l0_run", int'(bus.state), 1);
        tick(1);
        check("t4_l0_done", int'(bus.done), 1);
        check("t4_l0_out", int'(bus.out), 0);
        bus.limit = 8'd255; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(255);
        check("t4_out255", int'(bus.out), 255);
        tick(1);
        check("t4_done255", int'(bus.done), 1);
        check("t4_nowrap", int'(bus.out), 255);
        // restart from DONE with limit 3; mid-run limit change and start ignored
        bus.limit = 8'd3; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("t5_restart", int'(bus.out), 0);
        tick(1);
        bus.limit = 8'd9; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("t5_ignored", int'(bus.out), 2);
        tick(1);
        check("t5_out3", int'(bus.out), 3);
        tick(1);
        check("t5_done", int'(bus.done), 1);
        check("t5_final", int'(bus.out), 3);
`else
        // auto-reload, limit 2: 0,1,2,0,1,2 with done on every reload
        bus.limit = 8'd2; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick(1);
            check("ar_out", int'(bus.out), k % 3);
            check("ar_done", int'(bus.done), int'(k > 0 && k % 3 == 0));
            check("ar_busy", int'(bus.busy), 1);
        end
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("ar_stop_busy", int'(bus.busy), 0);
        check("ar_stop_out", int'(bus.out), 0);
`endif
        // synchronous reset mid-run
        bus.limit = 8'd20; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(5);
        check("t6_out5", int'(bus.out), 5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_out", int'(bus.out), 0);
        check("t6_rst_state", int'(bus.state), 0);
        check("t6_rst_busy", int'(bus.busy), 0);
        check("t6_rst_done", int'(bus.done), 0);
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run controller for the 8-bit up-counter datapath. It owns the count register and sequences it through start / hold / terminal-count / stop, so the counter can run bounded, programmable periods instead of free-running from reset. It sits between the control logic (or bench) and any consumer of `out`. Start, hold and stop inputs are sampled every clock, and completion is signalled with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: width of the count and of `limit`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: level-sampled; begins a run from IDLE or DONE.
- `stop`  in  1: level-sampled; aborts any state back to IDLE.
- `hold`  in  1: level-sampled; freezes the count while in RUN/HOLD.
- `limit`  in  WIDTH: terminal count, latched when a start is accepted.
- `out`  out  WIDTH: current count, registered.
- `busy`  out  1: high in RUN or HOLD.
- `done`  out  1: registered one-cycle pulse when the terminal count completes.
- `state`  out  2: encoding IDLE=0, RUN=1, HOLD=2, DONE=3.

## Operation
- Priority at every edge:
  - `rst` first.
  - `stop` second.
  - Then the state-specific action.
- Reset: `state`=IDLE, `out`=0, `limit_q`=0, `done`=0, `busy`=0.
- Stop: any state goes to IDLE, `out`<=0, `done`<=0. If `start` and `stop` are high together, stop wins.
- IDLE:
  - `start`=1 latches `limit` into `limit_q`, sets `out`<=0 and goes to RUN.
  - Otherwise the block holds.
- RUN and HOLD:
  - `start` is ignored, and `limit` changes have no effect until the next accepted start.
  - If `hold`=1: go to HOLD, `out` unchanged.
  - If `hold`=0 and `out` != `limit_q`: go to RUN, `out`<=`out`+1.
  - If `hold`=0 and `out` == `limit_q`: terminal action (see Configuration). With the feature out, this means go to DONE with `done`<=1.
- DONE:
  - `out` holds `limit_q`, `busy`=0, and `done` is 1 only in the first DONE cycle.
  - `start`=1 relatches `limit`, sets `out`<=0 and goes to RUN.
- `done` is 0 in every cycle other than the terminal-action cycle.
- Arithmetic: the increment is modulo 2^WIDTH. Overflow cannot occur, because `out` never passes `limit_q` (max 2^WIDTH-1).
- `busy` and `state` are decodes of the registered state; they are glitch-free with no extra latency.

## Timing
- Start accepted at edge N:
  - `out`=0, `busy`=1 after N.
  - `out`=k after edge N+k.
  - `out`=L after edge N+L.
  - `done`=1 after edge N+L+1.
- Latency from start to `done` is L+1 cycles with no holds. Each cycle with `hold`=1 in RUN/HOLD adds exactly one cycle.
- `limit`=0: `done` asserts after edge N+1, and `out` stays 0.
- Leaving HOLD costs no cycles: the first edge with `hold`=0 increments.
- Stop takes effect at the sampling edge: `out`=0 and `busy`=0 the following cycle.
- Reset mid-run behaves identically to a stop, and also clears `limit_q`.

## Configuration
- Macro `COUNTER_CTRL_AUTORELOAD_EN`.
- Defined: the terminal action is `out`<=0, stay in RUN/HOLD logic, `done`<=1 for one cycle. The block therefore produces a `done` pulse every L+1 non-held cycles until `stop`. DONE is unreachable but kept in the encoding.
- Undefined: the terminal action goes to DONE as described under Operation; one-shot behaviour.

## Test plan
- Reset, then `start`=1 for one cycle with `limit`=5 -> `out` runs 0,1,2,3,4,5; `done`=1 exactly one cycle later; `out` holds 5; `state`=3; `busy`=0.
- `limit`=10 run with `hold`=1 for 3 cycles starting when `out`=4 -> `out` stays 4 for 3 cycles; `state`=2 meanwhile; `done` arrives 14 cycles after start.
- Run with `limit`=200 and `stop`=1 when `out`=50 -> next cycle `out`=0, `state`=0, no `done`. Separately, `start` and `stop` high together in IDLE -> remains IDLE.
- `limit`=0 start -> `done` one cycle later, `out` always 0. Also `limit`=255 -> reaches 255, `done` fires, no wrap to 0.
- In DONE, `start` with `limit`=3 -> restarts at 0 and finishes after 4 cycles. During RUN, change `limit` and pulse `start` -> both ignored, original terminal used.
- With `COUNTER_CTRL_AUTORELOAD_EN` and `limit`=2 -> `out` sequence 0,1,2,0,1,2…, `done` every 3rd cycle, `busy` stays 1 until `stop`. Synchronous `rst` mid-run -> all outputs 0 the next cycle.
